emulib_burst_packer: RTL and testbench

//   Width upsizer in front of emulib_fifo (USE_BURST=1). Packs RATIO

---
 rtl/emulib_burst_packer_if.sv | 29 ++
 rtl/emulib_burst_packer.sv | 66 ++++++
 tb/tb_emulib_burst_packer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/emulib_burst_packer_if.sv
// Handshake bundle for the burst packer: narrow beat input side and
// packed word output side, grouped so master drives beats and takes words.
interface emulib_burst_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int IDXW      = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic                 ivalid;
    logic                 iready;
    logic [IN_WIDTH-1:0]  idata;
    logic                 ilast;
    logic                 ovalid;
    logic                 oready;
    logic [OUT_WIDTH-1:0] odata;
    logic                 olast;
    logic [IDXW:0]        ocount;

    modport master (
        output ivalid, idata, ilast, oready,
        input  iready, ovalid, odata, olast, ocount
    );

    modport slave (
        input  ivalid, idata, ilast, oready,
        output iready, ovalid, odata, olast, ocount
    );
endinterface

// File: rtl/emulib_burst_packer.sv
// Width upsizer: packs RATIO narrow beats into one wide word, lane 0 first;
// a burst end flushes a partial word early with zeroed upper lanes.
module emulib_burst_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input logic clk,
    input logic rst,
    emulib_burst_packer_if.slave bus
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int IDXW      = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RATIO - 1);

    logic [OUT_WIDTH-1:0] pack_data;
    logic [IDXW-1:0]      idx;
    logic [OUT_WIDTH-1:0] odata_q;
    logic                 olast_q;
    logic [IDXW:0]        ocount_q;
    logic                 ovalid_q;

    logic                 accept;
    logic                 complete;
    logic [OUT_WIDTH-1:0] merged;

    // Ready depends only on the output register, never on the input beat.
    assign bus.iready = !ovalid_q || bus.oready;
    assign accept     = bus.ivalid && bus.iready;
    assign complete   = accept && (idx == LAST_IDX || bus.ilast);

    always_comb begin
        merged = pack_data;
        merged[idx*IN_WIDTH +: IN_WIDTH] = bus.idata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_data <= '0;
            idx       <= '0;
            odata_q   <= '0;
            olast_q   <= 1'b0;
            ocount_q  <= '0;
            ovalid_q  <= 1'b0;
        end else if (complete) begin
            odata_q   <= merged;
            olast_q   <= bus.ilast;
            ocount_q  <= {1'b0, idx} + (IDXW+1)'(1);
            ovalid_q  <= 1'b1;
            pack_data <= '0;
            idx       <= '0;
        end else begin
            if (accept) begin
                pack_data <= merged;
                idx       <= idx + IDXW'(1);
            end
            if (ovalid_q && bus.oready) begin
                ovalid_q <= 1'b0;
            end
        end
    end

    assign bus.odata  = odata_q;
    assign bus.olast  = olast_q;
    assign bus.ocount = ocount_q;
    assign bus.ovalid = ovalid_q;
endmodule

// File: tb/tb_emulib_burst_packer.sv
// Directed bench for emulib_burst_packer: RATIO=4 vector table plus
// hand-written reset and RATIO=1 sequences.
module tb_emulib_burst_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ntests = 0;
    int   nfail  = 0;

    always #5 clk = ~clk;

    emulib_burst_packer_if #(.IN_WIDTH(8), .RATIO(4)) b4 ();
    emulib_burst_packer_if #(.IN_WIDTH(8), .RATIO(1)) b1 ();

    emulib_burst_packer #(.IN_WIDTH(8), .RATIO(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    emulib_burst_packer #(.IN_WIDTH(8), .RATIO(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    typedef struct {
        logic        iv;
        logic [7:0]  d;
        logic        l;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ol;
        logic [2:0]  e_oc;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic iv, input logic [7:0] d, input logic l,
                     input logic ordy, input logic e_irdy, input logic e_ov,
                     input logic [31:0] e_od, input logic e_ol,
                     input logic [2:0] e_oc);
        vec_t t;
        t.iv = iv; t.d = d; t.l = l; t.ordy = ordy;
        t.e_irdy = e_irdy; t.e_ov = e_ov; t.e_od = e_od;
        t.e_ol = e_ol; t.e_oc = e_oc;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int n,
                         input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s[%0d]: got %h, want %h", name, n, act, exp);
        end
    endtask

    task automatic drive4(input logic iv, input logic [7:0] d,
                          input logic l, input logic ordy);
        b4.ivalid = iv;
        b4.idata  = d;
        b4.ilast  = l;
        b4.oready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive4(1'b0, 8'h00, 1'b0, 1'b1);
        b1.ivalid = 1'b0;
        b1.idata  = 8'h00;
        b1.ilast  = 1'b0;
        b1.oready = 1'b1;

        // Expected fields describe the outputs while the inputs are presented.
        v(1, 8'h11, 0, 1, 1, 0, 32'h0, 0, 0);
        v(1, 8'h22, 0, 1, 1, 0, 32'h0, 0, 0);
        v(1, 8'h33, 0, 1, 1, 0, 32'h0, 0, 0);
        v(1, 8'h44, 1, 1, 1, 0, 32'h0, 0, 0);
        v(1, 8'hAA, 0, 1, 1, 1, 32'h44332211, 1, 4);
        v(1, 8'hBB, 1, 1, 1, 0, 32'h44332211, 1, 4);
        v(0, 8'h00, 0, 1, 1, 1, 32'h0000BBAA, 1, 2);
        v(1, 8'h01, 0, 1, 1, 0, 32'h0000BBAA, 1, 2);
        v(1, 8'h02, 0, 1, 1, 0, 32'h0000BBAA, 1, 2);
        v(1, 8'h03, 0, 1, 1, 0, 32'h0000BBAA, 1, 2);
        v(1, 8'h04, 0, 1, 1, 0, 32'h0000BBAA, 1, 2);
        for (int i = 0; i < 5; i++)
            v(1, 8'h05, 0, 0, 0, 1, 32'h04030201, 0, 4);
        v(1, 8'h05, 0, 1, 1, 1, 32'h04030201, 0, 4);
        v(1, 8'h06, 0, 1, 1, 0, 32'h04030201, 0, 4);
        v(1, 8'h07, 0, 1, 1, 0, 32'h04030201, 0, 4);
        v(1, 8'h08, 0, 1, 1, 0, 32'h04030201, 0, 4);
        v(0, 8'h00, 0, 1, 1, 1, 32'h08070605, 0, 4);
        v(0, 8'h00, 0, 1, 1, 0, 32'h08070605, 0, 4);
        v(1, 8'hA1, 1, 1, 1, 0, 32'h08070605, 0, 4);
        v(1, 8'hA2, 1, 1, 1, 1, 32'h000000A1, 1, 1);
        v(1, 8'hA3, 1, 1, 1, 1, 32'h000000A2, 1, 1);
        v(0, 8'h00, 0, 1, 1, 1, 32'h000000A3, 1, 1);
        v(0, 8'h00, 0, 1, 1, 0, 32'h000000A3, 1, 1);
        v(1, 8'hC1, 0, 1, 1, 0, 32'h000000A3, 1, 1);
        v(1, 8'hC2, 0, 1, 1, 0, 32'h000000A3, 1, 1);
        v(1, 8'hC3, 0, 1, 1, 0, 32'h000000A3, 1, 1);
        v(1, 8'hC4, 0, 1, 1, 0, 32'h000000A3, 1, 1);
        v(1, 8'hD1, 1, 1, 1, 1, 32'hC4C3C2C1, 0, 4);
        v(0, 8'h00, 0, 1, 1, 1, 32'h000000D1, 1, 1);
        v(0, 8'h00, 0, 1, 1, 0, 32'h000000D1, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ovalid", 0, 32'(b4.ovalid), 32'h0);
        check("rst_odata", 0, b4.odata, 32'h0);
        check("rst_ocount", 0, 32'(b4.ocount), 32'h0);

        foreach (vecs[i]) begin
            drive4(vecs[i].iv, vecs[i].d, vecs[i].l, vecs[i].ordy);
            #1;
            check("iready", i, 32'(b4.iready), 32'(vecs[i].e_irdy));
            check("ovalid", i, 32'(b4.ovalid), 32'(vecs[i].e_ov));
            check("odata", i, b4.odata, vecs[i].e_od);
            check("olast", i, 32'(b4.olast), 32'(vecs[i].e_ol));
            check("ocount", i, 32'(b4.ocount), 32'(vecs[i].e_oc));
            step();
        end

        // Reset mid-word: two beats packed, then discarded.
        drive4(1'b1, 8'hE1, 1'b0, 1'b1);
        step();
        drive4(1'b1, 8'hE2, 1'b0, 1'b1);
        step();
        drive4(1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        check("mid_rst_ovalid", 0, 32'(b4.ovalid), 32'h0);
        rst = 1'b0;
        check("post_rst_odata", 0, b4.odata, 32'h0);
        begin
            logic [7:0] seq [4];
            seq[0] = 8'h55; seq[1] = 8'h66; seq[2] = 8'h77; seq[3] = 8'h88;
            for (int k = 0; k < 4; k++) begin
                drive4(1'b1, seq[k], k == 3, 1'b1);
                #1;
                check("post_rst_ovalid", k, 32'(b4.ovalid), 32'h0);
                step();
            end
        end
        drive4(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        check("post_rst_ov", 1, 32'(b4.ovalid), 32'h1);
        check("post_rst_od", 1, b4.odata, 32'h88776655);
        check("post_rst_ol", 1, 32'(b4.olast), 32'h1);
        check("post_rst_oc", 1, 32'(b4.ocount), 32'h4);
        step();
        check("post_rst_drain", 1, 32'(b4.ovalid), 32'h0);

        // RATIO=1: register slice, every beat is its own word.
        begin
            logic [7:0] d1 [3];
            d1[0] = 8'h05; d1[1] = 8'h06; d1[2] = 8'h07;
            check("r1_idle_ovalid", 0, 32'(b1.ovalid), 32'h0);
            for (int k = 0; k < 3; k++) begin
                b1.ivalid = 1'b1;
                b1.idata  = d1[k];
                b1.ilast  = (k == 2);
                step();
                b1.ivalid = 1'b0;
                #1;
                check("r1_ovalid", k, 32'(b1.ovalid), 32'h1);
                check("r1_odata", k, 32'(b1.odata), 32'(d1[k]));
                check("r1_ocount", k, 32'(b1.ocount), 32'h1);
                check("r1_olast", k, 32'(b1.olast), 32'(k == 2));
            end
            step();
            check("r1_drain", 0, 32'(b1.ovalid), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
